// File: rtl/axi_write_master_pkg.sv
// rtl/axi_write_master_pkg.sv - shared types, AXI constants and 4 KB helper for axi_write_master
package axi_write_master_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACTIVE = 2'd1,
      DONE   = 2'd2
   } state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;

   // Whole beats that fit between addr and the next 4 KB page boundary.
   function automatic logic [12:0] beats_to_4k(input logic [11:0] addr, input logic [12:0] bytes);
      logic [12:0] span;
      span = 13'h1000 - {1'b0, addr};
      return span / bytes;
   endfunction

endpackage

// File: rtl/axi_burst_fifo.sv
// rtl/axi_burst_fifo.sv - burst-length FIFO linking AW issue to W completion
module axi_burst_fifo #(
   parameter int DEPTH = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       push,
   input  logic [7:0] push_len,
   input  logic       pop,
   output logic [7:0] head_len,
   output logic       full,
   output logic       empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [7:0]       mem_q [DEPTH];
   logic [7:0]       mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   assign full     = (count_q == CNT_W'(DEPTH));
   assign empty    = (count_q == '0);
   assign head_len = mem_q[rd_ptr_q];

   always_comb begin
      do_push  = push && !full;
      do_pop   = pop && !empty;
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_len;
         wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/axi_write_master.sv
// rtl/axi_write_master.sv - command-driven AXI4 write master splitting a stream into 4 KB-safe INCR bursts
module axi_write_master
   import axi_write_master_pkg::*;
#(
   parameter int C_M_AXI_ADDR_WIDTH = 64,
   parameter int C_M_AXI_DATA_WIDTH = 256,
   parameter int C_XFER_SIZE_WIDTH  = 32,
   parameter int C_MAX_BURST_LEN    = 64,
   parameter int C_MAX_OUTSTANDING  = 16
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            write_out_data,
   input  logic [C_M_AXI_ADDR_WIDTH-1:0]   write_addr,
   input  logic [C_XFER_SIZE_WIDTH-1:0]    out_data_size,
   input  logic [C_M_AXI_DATA_WIDTH-1:0]   out_data,
   input  logic                            out_data_valid,
   output logic                            out_data_ready,
   output logic                            write_done,
   output logic                            write_error,
   output logic                            m_axi_awvalid,
   input  logic                            m_axi_awready,
   output logic [C_M_AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
   output logic [7:0]                      m_axi_awlen,
   output logic [2:0]                      m_axi_awsize,
   output logic [1:0]                      m_axi_awburst,
   output logic                            m_axi_wvalid,
   input  logic                            m_axi_wready,
   output logic [C_M_AXI_DATA_WIDTH-1:0]   m_axi_wdata,
   output logic [C_M_AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
   output logic                            m_axi_wlast,
   input  logic                            m_axi_bvalid,
   output logic                            m_axi_bready,
   input  logic [1:0]                      m_axi_bresp
);

   localparam int BYTES = C_M_AXI_DATA_WIDTH / 8;
   localparam int SHIFT = $clog2(BYTES);
   localparam int LB_W  = SHIFT + 1;
   localparam int XW    = C_XFER_SIZE_WIDTH;
   localparam int AW    = C_M_AXI_ADDR_WIDTH;
   localparam logic [BYTES-1:0] STRB_ALL = '1;

   state_e         state_q, state_d;
   logic [AW-1:0]  addr_q, addr_d;
   logic [XW-1:0]  aw_left_q, aw_left_d;
   logic [XW-1:0]  w_left_q, w_left_d;
   logic [XW-1:0]  beat_q, beat_d;
   logic [XW-1:0]  issued_q, issued_d;
   logic [XW-1:0]  resp_q, resp_d;
   logic [LB_W-1:0] last_bytes_q, last_bytes_d;
   logic           error_q, error_d;
   logic           bready_q, bready_d;

   logic [XW-1:0]    to_4k, burst_beats, total_beats;
   logic [SHIFT-1:0] size_rem;
   logic             aw_fire, w_active, w_fire, w_last, b_fire;
   logic             fifo_full, fifo_empty;
   logic [7:0]       fifo_head;

   // Burst length is clipped by what is left, the burst cap and the 4 KB page edge.
   always_comb begin
      to_4k       = XW'(beats_to_4k(addr_q[11:0], 13'(BYTES)));
      burst_beats = aw_left_q;
      if (burst_beats > XW'(C_MAX_BURST_LEN)) burst_beats = XW'(C_MAX_BURST_LEN);
      if (burst_beats > to_4k) burst_beats = to_4k;
   end

   assign m_axi_awvalid = (state_q == ACTIVE) && (aw_left_q != '0) && !fifo_full;
   assign m_axi_awaddr  = addr_q;
   assign m_axi_awlen   = (aw_left_q != '0) ? 8'(burst_beats - XW'(1)) : 8'd0;
   assign m_axi_awsize  = 3'(SHIFT);
   assign m_axi_awburst = BURST_INCR;
   assign aw_fire       = m_axi_awvalid && m_axi_awready;

   assign w_active       = (state_q == ACTIVE) && !fifo_empty;
   assign m_axi_wvalid   = w_active && out_data_valid;
   assign out_data_ready = w_active && m_axi_wready;
   assign m_axi_wdata    = out_data;
   assign w_last         = w_active && (beat_q == XW'(fifo_head));
   assign m_axi_wlast    = w_last;
   assign w_fire         = m_axi_wvalid && m_axi_wready;

   always_comb begin
      m_axi_wstrb = '0;
      if (w_active) begin
         if (w_left_q == XW'(1)) m_axi_wstrb = STRB_ALL >> (LB_W'(BYTES) - last_bytes_q);
         else                    m_axi_wstrb = STRB_ALL;
      end
   end

   assign m_axi_bready = bready_q;
   assign b_fire       = m_axi_bvalid && bready_q && (state_q == ACTIVE);
   assign write_done   = (state_q == DONE);
   assign write_error  = error_q;

   axi_burst_fifo #(
      .DEPTH (C_MAX_OUTSTANDING)
   ) u_burst_fifo (
      .clk      (clk),
      .reset    (reset),
      .push     (aw_fire),
      .push_len (m_axi_awlen),
      .pop      (w_fire && w_last),
      .head_len (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      aw_left_d    = aw_left_q;
      w_left_d     = w_left_q;
      beat_d       = beat_q;
      issued_d     = issued_q;
      resp_d       = resp_q;
      last_bytes_d = last_bytes_q;
      error_d      = error_q;
      bready_d     = 1'b1;
      size_rem     = out_data_size[SHIFT-1:0];
      total_beats  = (out_data_size >> SHIFT) + XW'(size_rem != '0);
      case (state_q)
         IDLE: begin
            if (write_out_data) begin
               addr_d       = write_addr & ~AW'(BYTES - 1);
               aw_left_d    = total_beats;
               w_left_d     = total_beats;
               beat_d       = '0;
               issued_d     = '0;
               resp_d       = '0;
               error_d      = 1'b0;
               last_bytes_d = (size_rem == '0) ? LB_W'(BYTES) : LB_W'(size_rem);
               state_d      = (total_beats == '0) ? DONE : ACTIVE;
            end
         end
         ACTIVE: begin
            if (aw_fire) begin
               addr_d    = addr_q + (AW'(burst_beats) << SHIFT);
               aw_left_d = aw_left_q - burst_beats;
               issued_d  = issued_q + XW'(1);
            end
            if (w_fire) begin
               w_left_d = w_left_q - XW'(1);
               beat_d   = w_last ? '0 : beat_q + XW'(1);
            end
            if (b_fire) begin
               resp_d = resp_q + XW'(1);
               if (m_axi_bresp != RESP_OKAY) error_d = 1'b1;
            end
            // Looking at next-cycle counts lets done follow the last response by one cycle.
            if ((aw_left_d == '0) && (w_left_d == '0) && (resp_d == issued_d)) state_d = DONE;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         addr_q       <= '0;
         aw_left_q    <= '0;
         w_left_q     <= '0;
         beat_q       <= '0;
         issued_q     <= '0;
         resp_q       <= '0;
         last_bytes_q <= '0;
         error_q      <= 1'b0;
         bready_q     <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         aw_left_q    <= aw_left_d;
         w_left_q     <= w_left_d;
         beat_q       <= beat_d;
         issued_q     <= issued_d;
         resp_q       <= resp_d;
         last_bytes_q <= last_bytes_d;
         error_q      <= error_d;
         bready_q     <= bready_d;
      end
   end

endmodule

// File: tb/tb_axi_write_master.sv
// tb/tb_axi_write_master.sv - directed self-checking bench for axi_write_master
module tb_axi_write_master;

   logic         clk            = 1'b0;
   logic         reset          = 1'b1;
   logic         write_out_data = 1'b0;
   logic [63:0]  write_addr     = '0;
   logic [31:0]  out_data_size  = '0;
   logic [255:0] out_data       = '0;
   logic         out_data_valid = 1'b0;
   logic         out_data_ready;
   logic         write_done;
   logic         write_error;
   logic         m_axi_awvalid;
   logic         m_axi_awready  = 1'b0;
   logic [63:0]  m_axi_awaddr;
   logic [7:0]   m_axi_awlen;
   logic [2:0]   m_axi_awsize;
   logic [1:0]   m_axi_awburst;
   logic         m_axi_wvalid;
   logic         m_axi_wready   = 1'b0;
   logic [255:0] m_axi_wdata;
   logic [31:0]  m_axi_wstrb;
   logic         m_axi_wlast;
   logic         m_axi_bvalid   = 1'b0;
   logic         m_axi_bready;
   logic [1:0]   m_axi_bresp    = 2'b00;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int src_idx = 0;
   int src_end = 0;
   int pending_b = 0;
   int b_total = 0;
   int err_b = -1;
   int last_b_cyc = -1;
   bit rand_mode = 1'b0;

   int   aw0, w0, s0, b0, done_cyc;
   logic done_err;

   logic [63:0]  aw_addr_q[$];
   logic [7:0]   aw_len_q[$];
   logic [255:0] w_data_q[$];
   logic [31:0]  w_strb_q[$];
   logic         w_last_q[$];

   axi_write_master dut (
      .clk            (clk),
      .reset          (reset),
      .write_out_data (write_out_data),
      .write_addr     (write_addr),
      .out_data_size  (out_data_size),
      .out_data       (out_data),
      .out_data_valid (out_data_valid),
      .out_data_ready (out_data_ready),
      .write_done     (write_done),
      .write_error    (write_error),
      .m_axi_awvalid  (m_axi_awvalid),
      .m_axi_awready  (m_axi_awready),
      .m_axi_awaddr   (m_axi_awaddr),
      .m_axi_awlen    (m_axi_awlen),
      .m_axi_awsize   (m_axi_awsize),
      .m_axi_awburst  (m_axi_awburst),
      .m_axi_wvalid   (m_axi_wvalid),
      .m_axi_wready   (m_axi_wready),
      .m_axi_wdata    (m_axi_wdata),
      .m_axi_wstrb    (m_axi_wstrb),
      .m_axi_wlast    (m_axi_wlast),
      .m_axi_bvalid   (m_axi_bvalid),
      .m_axi_bready   (m_axi_bready),
      .m_axi_bresp    (m_axi_bresp)
   );

   always #5 clk = ~clk;

   // Record every handshake at the edge that completes it.
   always @(posedge clk) begin
      if (reset) begin
         pending_b = 0;
      end else begin
         if (m_axi_awvalid && m_axi_awready) begin
            aw_addr_q.push_back(m_axi_awaddr);
            aw_len_q.push_back(m_axi_awlen);
         end
         if (m_axi_wvalid && m_axi_wready) begin
            w_data_q.push_back(m_axi_wdata);
            w_strb_q.push_back(m_axi_wstrb);
            w_last_q.push_back(m_axi_wlast);
            if (m_axi_wlast) pending_b = pending_b + 1;
         end
         if (out_data_valid && out_data_ready) src_idx = src_idx + 1;
         if (m_axi_bvalid && m_axi_bready) begin
            pending_b  = pending_b - 1;
            b_total    = b_total + 1;
            last_b_cyc = cyc;
         end
      end
      cyc = cyc + 1;
   end

   // Slave and stream source respond on the falling edge.
   always @(negedge clk) begin
      m_axi_awready = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      m_axi_wready  = rand_mode ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (src_idx < src_end) begin
         out_data_valid = rand_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
         out_data       = {8{32'(src_idx)}};
      end else begin
         out_data_valid = 1'b0;
      end
      m_axi_bvalid = (pending_b > 0) && !reset;
      m_axi_bresp  = (b_total == err_b) ? 2'b10 : 2'b00;
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests = tests + 1;
      assert (obs === exp) else begin
         fails = fails + 1;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic start_cmd(input logic [63:0] addr, input logic [31:0] size);
      aw0 = aw_addr_q.size();
      w0  = w_data_q.size();
      s0  = src_idx;
      b0  = b_total;
      src_end = src_idx + int'((size + 32'd31) / 32'd32);
      write_addr     = addr;
      out_data_size  = size;
      write_out_data = 1'b1;
      @(negedge clk);
      write_out_data = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int max_cyc);
      int n = 0;
      while (n < max_cyc && write_done !== 1'b1) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done_seen"}, 64'(write_done), 64'd1);
      done_cyc = cyc;
      done_err = write_error;
      @(negedge clk);
      check({tag, "_done_pulse"}, 64'(write_done), 64'd0);
   endtask

   initial begin
      int bad;
      int n;

      repeat (3) @(negedge clk);
      check("rst_awvalid", 64'(m_axi_awvalid), 64'd0);
      check("rst_wvalid", 64'(m_axi_wvalid), 64'd0);
      check("rst_bready", 64'(m_axi_bready), 64'd0);
      check("rst_done", 64'(write_done), 64'd0);
      check("rst_error", 64'(write_error), 64'd0);
      check("rst_ready", 64'(out_data_ready), 64'd0);
      check("awsize", 64'(m_axi_awsize), 64'd5);
      check("awburst", 64'(m_axi_awburst), 64'd1);
      reset = 1'b0;
      @(negedge clk);
      check("bready_up", 64'(m_axi_bready), 64'd1);

      // Single beat
      start_cmd(64'h1000, 32'd32);
      check("t1_awvalid_n1", 64'(m_axi_awvalid), 64'd1);
      check("t1_awaddr_n1", m_axi_awaddr, 64'h1000);
      check("t1_awlen_n1", 64'(m_axi_awlen), 64'd0);
      wait_done("t1", 200);
      check("t1_nbursts", 64'(aw_addr_q.size() - aw0), 64'd1);
      check("t1_nbeats", 64'(w_data_q.size() - w0), 64'd1);
      check("t1_wstrb", 64'(w_strb_q[w0]), 64'hFFFF_FFFF);
      check("t1_wlast", 64'(w_last_q[w0]), 64'd1);
      check("t1_wdata", 64'(w_data_q[w0][31:0]), 64'(s0));

      // Partial final beat, unaligned start address
      start_cmd(64'h2005, 32'd40);
      wait_done("t2", 200);
      check("t2_awaddr", aw_addr_q[aw0], 64'h2000);
      check("t2_awlen", 64'(aw_len_q[aw0]), 64'd1);
      check("t2_nbeats", 64'(w_data_q.size() - w0), 64'd2);
      check("t2_strb0", 64'(w_strb_q[w0]), 64'hFFFF_FFFF);
      check("t2_strb1", 64'(w_strb_q[w0+1]), 64'h0000_00FF);
      check("t2_last0", 64'(w_last_q[w0]), 64'd0);
      check("t2_last1", 64'(w_last_q[w0+1]), 64'd1);
      check("t2_error", 64'(done_err), 64'd0);

      // 4 KB crossing
      start_cmd(64'h0FC0, 32'd256);
      wait_done("t3", 300);
      check("t3_nbursts", 64'(aw_addr_q.size() - aw0), 64'd2);
      check("t3_aw0_addr", aw_addr_q[aw0], 64'h0FC0);
      check("t3_aw0_len", 64'(aw_len_q[aw0]), 64'd1);
      check("t3_aw1_addr", aw_addr_q[aw0+1], 64'h1000);
      check("t3_aw1_len", 64'(aw_len_q[aw0+1]), 64'd5);
      check("t3_nbeats", 64'(w_data_q.size() - w0), 64'd8);
      check("t3_nresp", 64'(b_total - b0), 64'd2);
      check("t3_done_after_b", 64'(done_cyc), 64'(last_b_cyc + 1));

      // Long transfer with random backpressure
      rand_mode = 1'b1;
      start_cmd(64'h10000, 32'd8192);
      wait_done("t4", 6000);
      rand_mode = 1'b0;
      check("t4_nbursts", 64'(aw_addr_q.size() - aw0), 64'd4);
      bad = 0;
      for (int k = 0; k < 4; k++) begin
         if (aw_addr_q[aw0+k] !== 64'h10000 + 64'(k) * 64'd2048) bad++;
         if (aw_len_q[aw0+k] !== 8'd63) bad++;
      end
      check("t4_bursts", 64'(bad), 64'd0);
      check("t4_nbeats", 64'(w_data_q.size() - w0), 64'd256);
      bad = 0;
      for (int k = 0; k < 256; k++) begin
         if (w_data_q[w0+k][31:0] !== 32'(s0 + k)) bad++;
      end
      check("t4_data_order", 64'(bad), 64'd0);
      bad = 0;
      for (int k = 0; k < 256; k++) begin
         if (w_last_q[w0+k] !== ((k % 64) == 63)) bad++;
         if (w_strb_q[w0+k] !== 32'hFFFF_FFFF) bad++;
      end
      check("t4_last_strb", 64'(bad), 64'd0);

      // Error response, then cleared by the next command
      err_b = b_total + 1;
      start_cmd(64'h3FC0, 32'd256);
      wait_done("t5", 300);
      check("t5_error_at_done", 64'(done_err), 64'd1);
      check("t5_error_sticky", 64'(write_error), 64'd1);
      start_cmd(64'h6000, 32'd32);
      check("t5_error_clear", 64'(write_error), 64'd0);
      wait_done("t5b", 200);
      check("t5b_error", 64'(done_err), 64'd0);

      // Zero-size command
      start_cmd(64'h7000, 32'd0);
      check("t6_done_n1", 64'(write_done), 64'd1);
      check("t6_awvalid", 64'(m_axi_awvalid), 64'd0);
      @(negedge clk);
      check("t6_done_once", 64'(write_done), 64'd0);
      check("t6_no_aw", 64'(aw_addr_q.size() - aw0), 64'd0);

      // Reset in the middle of a burst, then a fresh command
      start_cmd(64'h8000, 32'd2048);
      n = 0;
      while ((w_data_q.size() - w0) < 10 && n < 300) begin
         @(negedge clk);
         n++;
      end
      check("t7_midburst", 64'((w_data_q.size() - w0) >= 10), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      check("t7_awvalid", 64'(m_axi_awvalid), 64'd0);
      check("t7_wvalid", 64'(m_axi_wvalid), 64'd0);
      check("t7_ready", 64'(out_data_ready), 64'd0);
      check("t7_done", 64'(write_done), 64'd0);
      check("t7_state", 64'(dut.state_q), 64'(axi_write_master_pkg::IDLE));
      reset = 1'b0;
      @(negedge clk);
      @(negedge clk);
      start_cmd(64'h9000, 32'd64);
      wait_done("t8", 200);
      check("t8_nbursts", 64'(aw_addr_q.size() - aw0), 64'd1);
      check("t8_awaddr", aw_addr_q[aw0], 64'h9000);
      check("t8_awlen", 64'(aw_len_q[aw0]), 64'd1);
      check("t8_nbeats", 64'(w_data_q.size() - w0), 64'd2);
      check("t8_wdata1", 64'(w_data_q[w0+1][31:0]), 64'(s0 + 1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
